seg7_scan_ctrl: RTL and testbench

- Memory-mapped controller for the 4-digit, common-anode seven-segment display on the CPU board.
- Sequences the anode scan and decodes hex nibbles to segments.
- Adds inter-digit blanking against ghosting, 16-level brightness PWM, per-digit enable, decimal points and leading-zero suppression.
- CPU writes go to pending registers; these are copied to shadow registers only at frame boundaries, so the display never tears.

---
 rtl/seg7_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller: CPU-visible pending
// registers, frame-synchronous shadow copies, anti-ghost blanking, PWM, LZ blanking.
module seg7_scan_ctrl #(
   parameter int DIV_W        = 16,
   parameter int BLANK_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [1:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam logic [15:0] CTRL_RESET = 16'hFF01;
   localparam logic [15:0] CTRL_WMASK = 16'hFFF3;

   typedef enum logic [1:0] {
      ADDR_VALUE = 2'd0,
      ADDR_CTRL  = 2'd1,
      ADDR_RSVD2 = 2'd2,
      ADDR_RSVD3 = 2'd3
   } addr_e;

   logic [15:0]      value_p;
   logic [15:0]      ctrl_p;
   logic [15:0]      value_s;
   logic             enable_s;
   logic             lz_s;
   logic [3:0]       dp_mask_s;
   logic [3:0]       digit_en_s;
   logic [3:0]       bright_s;

   logic [DIV_W-1:0] slot_cnt;
   logic [1:0]       digit;

   logic             slot_end;
   logic             boundary;
   logic             past_blank;
   logic             in_pwm;
   logic [3:0]       sup_mask;
   logic [3:0]       nibble;
   logic             lit;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // CPU-side pending registers; reserved CTRL bits are never stored.
   always_ff @(posedge clk) begin
      if (reset) begin
         value_p <= '0;
         ctrl_p  <= CTRL_RESET;
      end else if (wr_en) begin
         case (addr_e'(wr_addr))
            ADDR_VALUE: value_p <= wr_data;
            ADDR_CTRL:  ctrl_p  <= wr_data & CTRL_WMASK;
            default:    ;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr_e'(rd_addr))
         ADDR_VALUE: rd_data = value_p;
         ADDR_CTRL:  rd_data = ctrl_p;
         default:    rd_data = '0;
      endcase
   end

   assign slot_end = &slot_cnt;
   assign boundary = enable_s && slot_end && (digit == 2'd3);

   // A pending write in the boundary cycle lands after the shadows sampled the old value.
   always_ff @(posedge clk) begin
      if (reset) begin
         value_s    <= '0;
         enable_s   <= CTRL_RESET[0];
         lz_s       <= CTRL_RESET[1];
         dp_mask_s  <= CTRL_RESET[7:4];
         digit_en_s <= CTRL_RESET[11:8];
         bright_s   <= CTRL_RESET[15:12];
      end else if (!enable_s || boundary) begin
         value_s    <= value_p;
         enable_s   <= ctrl_p[0];
         lz_s       <= ctrl_p[1];
         dp_mask_s  <= ctrl_p[7:4];
         digit_en_s <= ctrl_p[11:8];
         bright_s   <= ctrl_p[15:12];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !enable_s) begin
         slot_cnt <= '0;
         digit    <= '0;
      end else begin
         slot_cnt <= slot_cnt + DIV_W'(1);
         if (slot_end) begin
            digit <= digit + 2'd1;
         end
      end
   end

   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign past_blank = 1'b1;
   end else begin : g_blank
      localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
      assign past_blank = (slot_cnt >= BLANK_END);
   end

   assign in_pwm = (slot_cnt[DIV_W-1 -: 4] <= bright_s);

   always_comb begin
      sup_mask = '0;
      if (lz_s) begin
         sup_mask[3] = (value_s[15:12] == 4'h0);
         sup_mask[2] = (value_s[15:8]  == 8'h00);
         sup_mask[1] = (value_s[15:4]  == 12'h000);
      end
   end

   assign nibble = value_s[{digit, 2'b00} +: 4];
   assign lit    = enable_s && digit_en_s[digit] && past_blank && in_pwm && !sup_mask[digit];

   always_ff @(posedge clk) begin
      if (reset) begin
         an         <= '1;
         seg        <= '1;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (lit) begin
            an  <= ~(4'b0001 << digit);
            seg <= hex7(nibble);
            dp  <= ~dp_mask_s[digit];
         end else begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: frame-position reference model,
// register readback table, directed multi-frame sequences and random traffic.
module tb_seg7_scan_ctrl;

   localparam int DIV_W = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = 1 << DIV_W;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   seg7_scan_ctrl #(.DIV_W(DIV_W), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .an(an), .seg(seg), .dp(dp),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: display state is a frame position 0..FRAME-1 rather than counters.
   logic [6:0]  hex_tab [16];
   logic [15:0] m_pv, m_pc, m_sv, m_sc;
   int          m_pos;
   logic [3:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dp, m_fd;

   logic [3:0]  an_log  [FRAME];
   logic [6:0]  seg_log [FRAME];
   logic        dp_log  [FRAME];
   logic        fd_log  [FRAME];

   typedef struct {
      logic [1:0]  addr;
      logic [15:0] data;
      logic [1:0]  raddr;
      logic [15:0] exp;
   } rd_vec_t;
   rd_vec_t rv [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      int   d, s;
      logic en, lit, supp;
      if (reset) begin
         m_pv = 16'h0000; m_pc = 16'hFF01; m_sv = 16'h0000; m_sc = 16'hFF01;
         m_pos = 0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_fd = 1'b0;
      end else begin
         en   = m_sc[0];
         d    = m_pos / SLOT;
         s    = m_pos % SLOT;
         supp = m_sc[1] && (d > 0) && ((m_sv >> (4 * d)) == 16'h0000);
         lit  = en && m_sc[8 + d] && (s >= BLANK) && ((s >> (DIV_W - 4)) <= int'(m_sc[15:12])) && !supp;
         m_an  = lit ? (4'hF ^ (4'b0001 << d)) : 4'hF;
         m_seg = lit ? hex_tab[4'(m_sv >> (4 * d))] : 7'h7F;
         m_dp  = lit ? ~m_sc[4 + d] : 1'b1;
         m_fd  = en && (m_pos == FRAME - 1);
         if (!en || m_pos == FRAME - 1) begin
            m_sv = m_pv;
            m_sc = m_pc;
         end
         m_pos = en ? (m_pos + 1) % FRAME : 0;
         if (wr_en && wr_addr == 2'd0) m_pv = wr_data;
         if (wr_en && wr_addr == 2'd1) m_pc = wr_data & 16'hFFF3;
      end
   endtask

   task automatic compare_all();
      logic [15:0] exp_rd;
      check("an", an, m_an);
      check("seg", seg, m_seg);
      check("dp", dp, m_dp);
      check("frame_done", frame_done, m_fd);
      exp_rd = (rd_addr == 2'd0) ? m_pv : (rd_addr == 2'd1) ? m_pc : 16'h0000;
      check("rd_data", rd_data, exp_rd);
      check("one_anode", ($countones(~an) <= 1), 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_fd();
      bit seen = 0;
      for (int k = 0; k < 2 * FRAME && !seen; k++) begin
         tick();
         if (frame_done === 1'b1) seen = 1;
      end
      check("wait_frame_done", seen, 1);
   endtask

   // Logs one frame; entry j shows the outputs produced by frame position j.
   task automatic capture(input bit do_wr, input int wr_pos, input logic [1:0] a, input logic [15:0] d);
      for (int j = 0; j < FRAME; j++) begin
         if (do_wr && j == wr_pos) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d;
         end
         tick();
         wr_en = 1'b0;
         an_log[j] = an; seg_log[j] = seg; dp_log[j] = dp; fd_log[j] = frame_done;
      end
   endtask

   function automatic int lit_count(input int lo, input int hi);
      int n = 0;
      for (int j = lo; j <= hi; j++) if (an_log[j] != 4'hF) n++;
      return n;
   endfunction

   initial begin
      int bad;
      hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      rv[0] = '{2'd1, 16'hFFFF, 2'd1, 16'hFFF3};
      rv[1] = '{2'd0, 16'hBEEF, 2'd0, 16'hBEEF};
      rv[2] = '{2'd2, 16'h1234, 2'd2, 16'h0000};
      rv[3] = '{2'd3, 16'hFFFF, 2'd3, 16'h0000};
      rv[4] = '{2'd2, 16'h5555, 2'd0, 16'hBEEF};
      rv[5] = '{2'd1, 16'h000C, 2'd1, 16'h0000};
      rv[6] = '{2'd1, 16'hFF01, 2'd1, 16'hFF01};

      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = 2'd1;
      tick();
      check("reset_an", an, 4'hF);
      check("reset_seg", seg, 7'h7F);
      check("reset_ctrl", rd_data, 16'hFF01);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         wr(rv[i].addr, rv[i].data);
         rd_addr = rv[i].raddr;
         #1;
         check("rd_table", rd_data, rv[i].exp);
      end

      // Basic scan of 12AF
      wr(2'd0, 16'h12AF);
      wait_fd();
      capture(0, 0, 2'd0, 16'h0);
      check("f1_an0_blank0", an_log[0], 4'hF);
      check("f1_an0_blank1", an_log[1], 4'hF);
      check("f1_an0_lit", an_log[2], 4'b1110);
      check("f1_seg0", seg_log[2], 7'b0001110);
      check("f1_an0_end", an_log[15], 4'b1110);
      check("f1_an1", an_log[18], 4'b1101);
      check("f1_seg1", seg_log[18], 7'b0001000);
      check("f1_an2", an_log[34], 4'b1011);
      check("f1_seg2", seg_log[34], 7'b0100100);
      check("f1_an3", an_log[63], 4'b0111);
      check("f1_seg3", seg_log[63], 7'b1111001);
      check("f1_fd_end", fd_log[63], 1);
      check("f1_fd_mid", fd_log[31], 0);

      // Mid-frame write, then a write on the boundary cycle itself
      capture(1, 30, 2'd0, 16'h3456);
      check("f2_old_d3", seg_log[50], 7'b1111001);
      check("f2_old_d2", seg_log[34], 7'b0100100);
      capture(1, 63, 2'd0, 16'h789A);
      check("f3_new_d0", seg_log[2], 7'b0000010);
      check("f3_new_d3", seg_log[50], 7'b0110000);
      capture(0, 0, 2'd0, 16'h0);
      check("f4_still_old", seg_log[2], 7'b0000010);
      capture(0, 0, 2'd0, 16'h0);
      check("f5_late_d0", seg_log[2], 7'b0001000);
      check("f5_late_d3", seg_log[50], 7'b1111000);

      // Leading-zero suppression
      wr(2'd1, 16'hFF03);
      wr(2'd0, 16'h0050);
      wait_fd();
      capture(0, 0, 2'd0, 16'h0);
      check("lz_d3_dark", lit_count(48, 63), 0);
      check("lz_d2_dark", lit_count(32, 47), 0);
      check("lz_d1_an", an_log[18], 4'b1101);
      check("lz_d1_seg", seg_log[18], 7'b0010010);
      check("lz_d0_seg", seg_log[2], 7'b1000000);
      wr(2'd0, 16'h0000);
      wait_fd();
      capture(0, 0, 2'd0, 16'h0);
      check("lz0_upper_dark", lit_count(16, 63), 0);
      check("lz0_d0_an", an_log[2], 4'b1110);
      check("lz0_d0_seg", seg_log[2], 7'b1000000);

      // Brightness 3 and decimal point on digit 2
      wr(2'd1, 16'h3F41);
      wait_fd();
      capture(0, 0, 2'd0, 16'h0);
      for (int d = 0; d < 4; d++) check("pwm_lit_count", lit_count(d * SLOT, d * SLOT + SLOT - 1), 2);
      check("pwm_slot3_lit", an_log[3], 4'b1110);
      check("pwm_slot4_dark", an_log[4], 4'hF);
      bad = 0;
      for (int j = 0; j < FRAME; j++) if (dp_log[j] == 1'b0) bad++;
      check("dp_count", bad, 2);
      check("dp_d2", {dp_log[34], dp_log[35]}, 2'b00);

      // Digit enable mask, disable, re-enable
      wr(2'd1, 16'hF501);
      wait_fd();
      capture(0, 0, 2'd0, 16'h0);
      check("den_d1_dark", lit_count(16, 31), 0);
      check("den_d3_dark", lit_count(48, 63), 0);
      check("den_d0_lit", lit_count(0, 15), 14);
      wr(2'd1, 16'hF500);
      wait_fd();
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) bad++;
      end
      check("disabled_idle", bad, 0);
      wr(2'd1, 16'hF501);
      tick();
      capture(0, 0, 2'd0, 16'h0);
      check("reen_d0", an_log[2], 4'b1110);
      check("reen_d0_dark", an_log[1], 4'hF);
      check("reen_fd", fd_log[63], 1);

      // Reset in the middle of digit 2
      wr(2'd0, 16'h1234);
      for (int k = 0; k < 34; k++) tick();
      check("pre_reset_d2", an, 4'b1011);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_reset_an", an, 4'hF);
      check("mid_reset_seg", seg, 7'h7F);
      rd_addr = 2'd1; #1;
      check("mid_reset_ctrl", rd_data, 16'hFF01);
      rd_addr = 2'd0; #1;
      check("mid_reset_value", rd_data, 16'h0000);
      capture(0, 0, 2'd0, 16'h0);
      check("post_reset_d0_an", an_log[2], 4'b1110);
      check("post_reset_d0_seg", seg_log[2], 7'b1000000);
      check("post_reset_fd", fd_log[63], 1);

      // Random traffic against the model
      for (int c = 0; c < 2500; c++) begin
         reset   = ($urandom_range(0, 299) == 0);
         rd_addr = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) begin
            wr_en   = 1'b1;
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 16'($urandom);
            if (wr_addr == 2'd1 && $urandom_range(0, 3) != 0) wr_data[0] = 1'b1;
         end else begin
            wr_en = 1'b0;
         end
         tick();
      end
      wr_en = 1'b0;
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
